// File: rtl/zktc_mem_pkg.sv
// zktc_mem_pkg
// Shared types for the zktc load/store unit:
//   mem_size_t  - access size encoding carried on req_size
//   mem_err_t   - response error code carried on resp_err
//   mem_state_t - load/store unit sequencing states
package zktc_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_SIZE     = 2'd3
  } mem_err_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } mem_state_t;

endpackage

// File: rtl/zktc_mem_lane.sv
// zktc_mem_lane
// Purely combinational byte-lane datapath of the load/store unit.
// Ports:
//   size       in  2      access size (mem_size_t encoding)
//   offset     in  LB     byte offset of the access within the bus word
//   sign       in  1      sign-extend the load result
//   wdata      in  XLEN   right-aligned store data
//   rdata      in  XLEN   raw bus read data
//   store_strb out XLEN/8 byte enables for the addressed lanes
//   store_data out XLEN   store data moved onto the addressed lanes
//   load_data  out XLEN   addressed lanes right-aligned and extended
module zktc_mem_lane
  import zktc_mem_pkg::*;
#(
  parameter int XLEN = 16,
  localparam int NB = XLEN / 8,
  localparam int LB = $clog2(NB)
) (
  input  logic [1:0]      size,
  input  logic [LB-1:0]   offset,
  input  logic            sign,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [NB-1:0]   store_strb,
  output logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] load_data
);

  logic [NB-1:0]   size_mask;
  logic [XLEN-1:0] lane_bits;
  logic [XLEN-1:0] shifted;
  logic            msb;

  // size_mask marks the bytes covered by the access when it sits at
  // offset 0; lane_bits is the same mask expanded to bit granularity.
  // The store path shifts both up to the addressed lane, the load path
  // shifts the bus word down and uses the unshifted mask to isolate
  // the value before filling the upper bits with the sign if requested.
  // Word size (and the illegal encoding, which never reaches here)
  // simply covers the whole bus.
  always_comb begin
    size_mask = '1;
    lane_bits = '0;
    msb       = 1'b0;
    case (mem_size_t'(size))
      SZ_BYTE: size_mask = NB'(1);
      SZ_HALF: size_mask = NB'(3);
      default: size_mask = '1;
    endcase
    for (int i = 0; i < NB; i++) begin
      lane_bits[i*8 +: 8] = {8{size_mask[i]}};
    end
    store_strb = size_mask << offset;
    store_data = (wdata & lane_bits) << {offset, 3'b000};
    shifted    = rdata >> {offset, 3'b000};
    case (mem_size_t'(size))
      SZ_BYTE: msb = shifted[7];
      SZ_HALF: msb = shifted[15];
      default: msb = 1'b0;
    endcase
    load_data = (shifted & lane_bits) | ((sign && msb) ? ~lane_bits : '0);
  end

endmodule

// File: rtl/zktc_mem_unit.sv
// zktc_mem_unit
// Load/store unit between the zktc MEMORY stage and the valid/ready
// memory bus. One request in flight; errors are reported on resp_err.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_we            1 = store, 0 = load
//   req_size          0 byte, 1 half, 2 word, 3 illegal
//   req_signed        sign-extend the load result
//   req_addr          byte address
//   req_wdata         right-aligned store data
//   resp_valid        one-cycle response pulse
//   resp_rdata        extended load data (0 for stores and errors)
//   resp_err          0 ok, 1 misaligned, 2 timeout, 3 illegal size
//   mem_valid         bus request
//   mem_addr          word-aligned bus address
//   mem_wstrb         byte-lane write enables (0 for loads)
//   mem_wdata         lane-steered store data
//   mem_ready         bus completion
//   mem_rdata         bus read data
module zktc_mem_unit
  import zktc_mem_pkg::*;
#(
  parameter int XLEN    = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic [1:0]        resp_err,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN/8-1:0] mem_wstrb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ready,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int NB    = XLEN / 8;
  localparam int LB    = $clog2(NB);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(NB - 1);
  localparam logic [CNT_W-1:0]  CNT_LIMIT  = CNT_W'(TIMEOUT);

  mem_state_t        state, state_d;
  logic              mem_valid_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [NB-1:0]     mem_wstrb_d;
  logic [XLEN-1:0]   mem_wdata_d;
  logic              resp_valid_d;
  logic [XLEN-1:0]   resp_rdata_d;
  mem_err_t          err_q, err_d;
  logic [CNT_W-1:0]  cnt, cnt_d, cnt_inc;

  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              sign_q, sign_d;
  logic [LB-1:0]     off_q, off_d;

  logic [1:0]        lane_size;
  logic [LB-1:0]     lane_off;
  logic [NB-1:0]     lane_strb;
  logic [XLEN-1:0]   lane_wdata;
  logic [XLEN-1:0]   lane_rdata;
  logic              size_bad;
  logic              misaligned;

  assign req_ready = (state == ST_IDLE);
  assign resp_err  = err_q;

  // The lane datapath is shared: while idle it steers the incoming store,
  // afterwards it extracts the load using the latched size and offset.
  assign lane_size = (state == ST_IDLE) ? req_size : size_q;
  assign lane_off  = (state == ST_IDLE) ? req_addr[LB-1:0] : off_q;

  zktc_mem_lane #(.XLEN(XLEN)) u_lane (
    .size       (lane_size),
    .offset     (lane_off),
    .sign       (sign_q),
    .wdata      (req_wdata),
    .rdata      (mem_rdata),
    .store_strb (lane_strb),
    .store_data (lane_wdata),
    .load_data  (lane_rdata)
  );

  // Request legality: size is checked before alignment so an illegal
  // size always reports ERR_SIZE regardless of the address.
  always_comb begin
    size_bad   = (mem_size_t'(req_size) == SZ_ILL) ||
                 ((mem_size_t'(req_size) == SZ_WORD) && (XLEN == 16));
    misaligned = 1'b0;
    case (mem_size_t'(req_size))
      SZ_HALF: misaligned = req_addr[0];
      SZ_WORD: misaligned = |req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  // The wait counter saturates so a huge TIMEOUT (or a disabled one)
  // never wraps back into a false match.
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  // Next-state and next-output logic. Every output except req_ready is
  // a register; this block computes what each register loads next.
  always_comb begin
    state_d      = state;
    mem_valid_d  = mem_valid;
    mem_addr_d   = mem_addr;
    mem_wstrb_d  = mem_wstrb;
    mem_wdata_d  = mem_wdata;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata;
    err_d        = err_q;
    cnt_d        = cnt;
    we_d         = we_q;
    size_d       = size_q;
    sign_d       = sign_q;
    off_d        = off_q;

    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          we_d   = req_we;
          size_d = req_size;
          sign_d = req_signed;
          off_d  = req_addr[LB-1:0];
          if (size_bad || misaligned) begin
            err_d        = size_bad ? ERR_SIZE : ERR_MISALIGN;
            resp_rdata_d = '0;
            resp_valid_d = 1'b1;
            state_d      = ST_RESP;
          end else begin
            mem_valid_d = 1'b1;
            mem_addr_d  = req_addr & ALIGN_MASK;
            mem_wstrb_d = req_we ? lane_strb : '0;
            mem_wdata_d = req_we ? lane_wdata : '0;
            cnt_d       = '0;
            state_d     = ST_BUS;
          end
        end
      end

      ST_BUS: begin
        if (mem_ready) begin
          mem_valid_d  = 1'b0;
          mem_wstrb_d  = '0;
          mem_wdata_d  = '0;
          resp_rdata_d = we_q ? '0 : lane_rdata;
          err_d        = ERR_NONE;
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
          if ((TIMEOUT != 0) && (cnt_inc == CNT_LIMIT)) begin
            mem_valid_d  = 1'b0;
            mem_wstrb_d  = '0;
            mem_wdata_d  = '0;
            resp_rdata_d = '0;
            err_d        = ERR_TIMEOUT;
            resp_valid_d = 1'b1;
            state_d      = ST_RESP;
          end
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d     = ST_IDLE;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_wstrb  <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      err_q      <= ERR_NONE;
      cnt        <= '0;
      we_q       <= 1'b0;
      size_q     <= '0;
      sign_q     <= 1'b0;
      off_q      <= '0;
    end else begin
      state      <= state_d;
      mem_valid  <= mem_valid_d;
      mem_addr   <= mem_addr_d;
      mem_wstrb  <= mem_wstrb_d;
      mem_wdata  <= mem_wdata_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= resp_rdata_d;
      err_q      <= err_d;
      cnt        <= cnt_d;
      we_q       <= we_d;
      size_q     <= size_d;
      sign_q     <= sign_d;
      off_q      <= off_d;
    end
  end

endmodule

// File: tb/tb_zktc_mem_unit.sv
// tb_zktc_mem_unit
// Drives a 32-bit unit (TIMEOUT 4) and a 16-bit unit (TIMEOUT 5) from one
// shared request/bus stimulus set; sel16 picks which unit is active and
// which unit's outputs are observed. Expected values come from an
// arithmetic model of the access rules.
module tb_zktc_mem_unit;

  localparam int TO32 = 4;
  localparam int TO16 = 5;

  typedef struct {
    logic [1:0]  err;
    logic [15:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel16;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        r32_req_ready, r32_resp_valid, r32_mem_valid;
  logic [31:0] r32_resp_rdata, r32_mem_wdata;
  logic [1:0]  r32_resp_err;
  logic [15:0] r32_mem_addr;
  logic [3:0]  r32_mem_wstrb;

  logic        r16_req_ready, r16_resp_valid, r16_mem_valid;
  logic [15:0] r16_resp_rdata, r16_mem_wdata;
  logic [1:0]  r16_resp_err;
  logic [15:0] r16_mem_addr;
  logic [1:0]  r16_mem_wstrb;

  logic        o_req_ready, o_resp_valid, o_mem_valid;
  logic [31:0] o_resp_rdata, o_mem_wdata;
  logic [1:0]  o_resp_err;
  logic [15:0] o_mem_addr;
  logic [3:0]  o_mem_wstrb;

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  zktc_mem_unit #(.XLEN(32), .ADDR_W(16), .TIMEOUT(TO32)) dut32 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid & ~sel16),
    .req_ready  (r32_req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (r32_resp_valid),
    .resp_rdata (r32_resp_rdata),
    .resp_err   (r32_resp_err),
    .mem_valid  (r32_mem_valid),
    .mem_addr   (r32_mem_addr),
    .mem_wstrb  (r32_mem_wstrb),
    .mem_wdata  (r32_mem_wdata),
    .mem_ready  (mem_ready & ~sel16),
    .mem_rdata  (mem_rdata)
  );

  zktc_mem_unit #(.XLEN(16), .ADDR_W(16), .TIMEOUT(TO16)) dut16 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid & sel16),
    .req_ready  (r16_req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata[15:0]),
    .resp_valid (r16_resp_valid),
    .resp_rdata (r16_resp_rdata),
    .resp_err   (r16_resp_err),
    .mem_valid  (r16_mem_valid),
    .mem_addr   (r16_mem_addr),
    .mem_wstrb  (r16_mem_wstrb),
    .mem_wdata  (r16_mem_wdata),
    .mem_ready  (mem_ready & sel16),
    .mem_rdata  (mem_rdata[15:0])
  );

  assign o_req_ready  = sel16 ? r16_req_ready  : r32_req_ready;
  assign o_resp_valid = sel16 ? r16_resp_valid : r32_resp_valid;
  assign o_resp_rdata = sel16 ? {16'h0, r16_resp_rdata} : r32_resp_rdata;
  assign o_resp_err   = sel16 ? r16_resp_err   : r32_resp_err;
  assign o_mem_valid  = sel16 ? r16_mem_valid  : r32_mem_valid;
  assign o_mem_addr   = sel16 ? r16_mem_addr   : r32_mem_addr;
  assign o_mem_wstrb  = sel16 ? {2'b00, r16_mem_wstrb} : r32_mem_wstrb;
  assign o_mem_wdata  = sel16 ? {16'h0, r16_mem_wdata} : r32_mem_wdata;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Reference model: the access rules written as plain byte arithmetic.
  function automatic exp_t model(input int xlen, input bit we, input int size,
                                 input bit sgn, input int addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata);
    exp_t   e;
    int     nb, off, nbytes;
    longint m, v;
    nb      = xlen / 8;
    off     = addr % nb;
    e.err   = 2'd0;
    e.addr  = 16'(addr - off);
    e.wstrb = 4'h0;
    e.wdata = 32'h0;
    e.rdata = 32'h0;
    if (size == 3 || (size == 2 && xlen == 16)) e.err = 2'd3;
    else if (addr % (1 << size) != 0) e.err = 2'd1;
    if (e.err == 2'd0) begin
      nbytes = 1 << size;
      m = (longint'(1) << (8 * nbytes)) - 1;
      if (we) begin
        e.wstrb = 4'(((1 << nbytes) - 1) << off);
        e.wdata = 32'((longint'(wdata) & m) << (8 * off));
      end else begin
        v = (longint'(rdata) >> (8 * off)) & m;
        if (sgn && v > m / 2) v = v - (m + 1);
        e.rdata = 32'(v & ((longint'(1) << xlen) - 1));
      end
    end
    return e;
  endfunction

  // One complete transaction: accept, optional bus phase with mem_ready
  // first raised in cycle k (k beyond the timeout means never), response.
  task automatic applyStimulus(input bit is16, input bit we, input int size,
                               input bit sgn, input logic [15:0] addr,
                               input logic [31:0] wdata_in,
                               input logic [31:0] rdata_in, input int k);
    exp_t        e;
    int          to, last;
    bit          timed;
    logic [31:0] wdata, rdata;
    wdata = is16 ? (wdata_in & 32'hFFFF) : wdata_in;
    rdata = is16 ? (rdata_in & 32'hFFFF) : rdata_in;
    e     = model(is16 ? 16 : 32, we, size, sgn, int'(addr), wdata, rdata);
    to    = is16 ? TO16 : TO32;

    @(negedge clk);
    sel16      = is16;
    mem_ready  = 1'b0;
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = 2'(size);
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    checkOutput("req_ready_idle", 32'(o_req_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = 16'($urandom);
    req_wdata  = $urandom;

    if (e.err != 2'd0) begin
      checkOutput("err_resp_valid", 32'(o_resp_valid), 32'h1);
      checkOutput("err_code", 32'(o_resp_err), 32'(e.err));
      checkOutput("err_rdata", o_resp_rdata, 32'h0);
      checkOutput("err_mem_valid", 32'(o_mem_valid), 32'h0);
      @(negedge clk);
      checkOutput("err_resp_drop", 32'(o_resp_valid), 32'h0);
      checkOutput("err_req_ready", 32'(o_req_ready), 32'h1);
      checkOutput("err_mem_valid2", 32'(o_mem_valid), 32'h0);
      return;
    end

    checkOutput("mem_addr", 32'(o_mem_addr), 32'(e.addr));
    checkOutput("mem_wstrb", 32'(o_mem_wstrb), 32'(e.wstrb));
    checkOutput("mem_wdata", o_mem_wdata, e.wdata);
    timed = (k > to);
    last  = timed ? to : k;
    for (int c = 1; c <= last; c++) begin
      checkOutput("mem_valid_bus", 32'(o_mem_valid), 32'h1);
      checkOutput("resp_valid_bus", 32'(o_resp_valid), 32'h0);
      if (c == k) begin
        mem_ready = 1'b1;
        mem_rdata = rdata;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    checkOutput("mem_valid_done", 32'(o_mem_valid), 32'h0);
    checkOutput("mem_wstrb_done", 32'(o_mem_wstrb), 32'h0);
    checkOutput("resp_valid", 32'(o_resp_valid), 32'h1);
    checkOutput("resp_err", 32'(o_resp_err), timed ? 32'h2 : 32'h0);
    checkOutput("resp_rdata", o_resp_rdata, timed ? 32'h0 : e.rdata);
    @(negedge clk);
    checkOutput("resp_drop", 32'(o_resp_valid), 32'h0);
    checkOutput("req_ready_back", 32'(o_req_ready), 32'h1);
  endtask

  initial begin
    rst        = 1'b1;
    sel16      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = 16'h0;
    req_wdata  = 32'h0;
    mem_ready  = 1'b0;
    mem_rdata  = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready32", 32'(r32_req_ready), 32'h1);
    checkOutput("rst_mem_valid32", 32'(r32_mem_valid), 32'h0);
    checkOutput("rst_resp_valid32", 32'(r32_resp_valid), 32'h0);
    checkOutput("rst_resp_rdata32", r32_resp_rdata, 32'h0);
    checkOutput("rst_resp_err32", 32'(r32_resp_err), 32'h0);
    checkOutput("rst_mem_addr32", 32'(r32_mem_addr), 32'h0);
    checkOutput("rst_mem_wstrb32", 32'(r32_mem_wstrb), 32'h0);
    checkOutput("rst_mem_wdata32", r32_mem_wdata, 32'h0);
    checkOutput("rst_mem_valid16", 32'(r16_mem_valid), 32'h0);
    checkOutput("rst_resp_valid16", 32'(r16_resp_valid), 32'h0);
    rst = 1'b0;

    $display("[TB] directed cases");
    applyStimulus(1'b0, 1'b0, 0, 1'b1, 16'h0003, 32'h0, 32'h80AB_CDEF, 2);
    applyStimulus(1'b0, 1'b1, 1, 1'b0, 16'h0002, 32'h0000_1234, 32'hDEAD_BEEF, 1);
    applyStimulus(1'b0, 1'b0, 2, 1'b0, 16'h0006, 32'h0, 32'h1111_2222, 1);
    applyStimulus(1'b1, 1'b0, 2, 1'b0, 16'h0000, 32'h0, 32'h0, 1);
    applyStimulus(1'b0, 1'b1, 3, 1'b0, 16'h0000, 32'h5555_5555, 32'h0, 1);
    applyStimulus(1'b0, 1'b0, 2, 1'b0, 16'h0010, 32'h0, 32'h1234_5678, TO32 + 1);
    applyStimulus(1'b0, 1'b0, 2, 1'b1, 16'h0010, 32'h0, 32'h8765_4321, TO32);
    applyStimulus(1'b1, 1'b0, 1, 1'b0, 16'h0004, 32'h0, 32'h0000_8001, 2);
    applyStimulus(1'b1, 1'b0, 0, 1'b1, 16'h0005, 32'h0, 32'h0000_9A7F, 1);
    applyStimulus(1'b1, 1'b1, 0, 1'b0, 16'h0007, 32'h0000_00C3, 32'h0, 3);
    applyStimulus(1'b1, 1'b0, 1, 1'b0, 16'h0008, 32'h0, 32'h0, TO16 + 1);

    $display("[TB] reset during bus phase");
    @(negedge clk);
    sel16      = 1'b0;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_size   = 2'd2;
    req_addr   = 16'h0020;
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    checkOutput("rst_mid_mem_valid_before", 32'(o_mem_valid), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_mid_mem_valid", 32'(o_mem_valid), 32'h0);
    checkOutput("rst_mid_resp_valid", 32'(o_resp_valid), 32'h0);
    @(negedge clk);
    checkOutput("rst_mid_req_ready", 32'(o_req_ready), 32'h1);
    checkOutput("rst_mid_no_resp", 32'(o_resp_valid), 32'h0);

    $display("[TB] random cases");
    for (int n = 0; n < 80; n++) begin
      bit          is16, we, sgn;
      int          size, to, k;
      logic [15:0] addr;
      is16 = 1'($urandom);
      we   = 1'($urandom);
      sgn  = 1'($urandom);
      size = int'($urandom_range(0, 3));
      addr = 16'($urandom);
      if ($urandom_range(0, 3) != 0) addr = addr & ~16'((1 << size) - 1);
      to   = is16 ? TO16 : TO32;
      k    = int'($urandom_range(1, to + 1));
      applyStimulus(is16, we, size, sgn, addr, $urandom, $urandom, k);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
